// File: rtl/dmem_pkg.sv
// Shared encodings and request-legality helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    // Unsigned variants only make sense for loads.
    function automatic logic memop_is_legal(input logic [2:0] op, input logic we);
        logic ok;
        case (op)
            MEMOP_B, MEMOP_H, MEMOP_W: ok = 1'b1;
            MEMOP_BU, MEMOP_HU:        ok = !we;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        case (op)
            MEMOP_W:            bad = (off != 2'b00);
            MEMOP_H, MEMOP_HU:  bad = off[0];
            default:            bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] m;
        case (op)
            MEMOP_B, MEMOP_BU: m = 4'b0001 << off;
            MEMOP_H, MEMOP_HU: m = off[1] ? 4'b1100 : 4'b0011;
            default:           m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load extraction/extension from a RAM word, plus the byte-lane mask for sub-word stores.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  st_off,
    input  logic [2:0]  st_op,
    output logic [31:0] rdata,
    output logic [3:0]  mask
);

    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;

    always_comb begin
        b_s = 8'(word >> {ld_off, 3'b000});
        h_s = ld_off[1] ? word[31:16] : word[15:0];
        case (ld_op)
            MEMOP_B:  rdata = 32'(b_s);
            MEMOP_BU: rdata = {24'b0, b_s};
            MEMOP_H:  rdata = 32'(h_s);
            MEMOP_HU: rdata = {16'b0, h_s};
            default:  rdata = word;
        endcase
    end

    assign mask = lane_mask(st_op, st_off);

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with RISC-V sub-word loads/stores.
// Define DMEM_BYTE_ENABLE_EN for a byte-lane RAM (single-cycle SB/SH, no MERGE state).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 32768,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata
);

    logic [31:0]   mem [DEPTH];
    state_t        state, state_d;
    logic          accept, req_err, rmw_start, mem_we;
    logic [AW-1:0] idx, wr_idx;
    logic [31:0]   wr_word, ld_data;
    logic [3:0]    lane_m;
    logic          unused_addr_hi;

    logic [31:0]   word_p1;
    logic [1:0]    off_p1;
    logic [2:0]    op_p1;
    logic          vld_p1, err_p1, ld_p1;

    assign idx            = req_addr[AW+1:2];
    assign unused_addr_hi = ^req_addr[31:AW+2];
    assign req_err        = !memop_is_legal(req_memop, req_we) || misaligned(req_memop, req_addr[1:0]);

    always_comb begin
        state_d   = state;
        req_ready = reset && (state == ST_IDLE);
        accept    = req_valid && req_ready;
        case (state)
            ST_IDLE:  if (rmw_start) state_d = ST_MERGE;
            ST_MERGE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            ld_p1  <= 1'b0;
        end else begin
            state  <= state_d;
            vld_p1 <= (accept && !rmw_start) || (state == ST_MERGE);
            err_p1 <= accept && req_err;
            ld_p1  <= accept && !req_we && !req_err;
        end
    end

`ifdef DMEM_BYTE_ENABLE_EN
    assign rmw_start = 1'b0;
    assign mem_we    = accept && req_we && !req_err;
    assign wr_idx    = idx;
    assign wr_word   = req_wdata << {req_addr[1:0], 3'b000};

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_m[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end
`else
    logic [31:0]   wdata_p1, bytes_m;
    logic [AW-1:0] idx_p1;

    assign rmw_start = accept && req_we && !req_err && (req_memop != MEMOP_W);
    assign mem_we    = (state == ST_MERGE) || (accept && req_we && !req_err && !rmw_start);
    assign wr_idx    = (state == ST_MERGE) ? idx_p1 : idx;

    always_comb begin
        for (int b = 0; b < 4; b++) bytes_m[8*b +: 8] = {8{lane_m[b]}};
    end

    // Old word from the accept-edge read, overlaid with the shifted store lanes.
    assign wr_word = (state == ST_MERGE)
                   ? ((word_p1 & ~bytes_m) | ((wdata_p1 << {off_p1, 3'b000}) & bytes_m))
                   : req_wdata;

    always_ff @(posedge clock) begin
        if (accept) begin
            wdata_p1 <= req_wdata;
            idx_p1   <= idx;
        end
        if (mem_we) mem[wr_idx] <= wr_word;
    end
`endif

    // Accept-edge stage: synchronous RAM read plus the request fields the response needs.
    always_ff @(posedge clock) begin
        if (accept) begin
            word_p1 <= mem[idx];
            off_p1  <= req_addr[1:0];
            op_p1   <= req_memop;
        end
    end

    dmem_load_align u_align (
        .word   (word_p1),
        .ld_off (off_p1),
        .ld_op  (op_p1),
`ifdef DMEM_BYTE_ENABLE_EN
        .st_off (req_addr[1:0]),
        .st_op  (req_memop),
`else
        .st_off (off_p1),
        .st_op  (op_p1),
`endif
        .rdata  (ld_data),
        .mask   (lane_m)
    );

    assign resp_valid = vld_p1;
    assign resp_err   = err_p1;
    assign resp_rdata = ld_p1 ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (DEPTH=1024 so address wrap is reachable).
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;
`ifdef DMEM_BYTE_ENABLE_EN
    localparam int SUB_LAT = 1;
`else
    localparam int SUB_LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_memop = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    dmem_responder #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_memop  (req_memop),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
        v.exp_err = err; v.exp_rd = rd;
        v.exp_lat = (we && !err && op != MEMOP_W) ? SUB_LAT : 1;
        return v;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that raised resp_valid.
    task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                         output logic err, output logic [31:0] rd, output int lat);
        int w = 0;
        req_valid = 1'b1; req_we = we; req_memop = op; req_addr = a; req_wdata = d;
        while (!req_ready && w < 10) begin
            @(posedge clock); #1; w++;
        end
        if (w >= 10) check("ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clock); #1; lat++;
        end
        err = resp_err;
        rd  = resp_rdata;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic        e;
        logic [31:0] r;
        int          l;
        for (int i = lo; i < hi; i++) begin
            issue(tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wdata, e, r, l);
            check($sformatf("v%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            check($sformatf("v%0d_rdata", i), r, tbl[i].exp_rd);
            check($sformatf("v%0d_lat", i), 32'(l), 32'(tbl[i].exp_lat));
        end
    endtask

    logic        e0;
    logic [31:0] r0;
    int          l0;

    initial begin
        // part A: word 0x100 = 0x80FF7F01, extension cases and error cases
        tbl.push_back(mk(1, MEMOP_W,  32'h100, 32'h80FF7F01, 0, 32'h0));
        tbl.push_back(mk(0, MEMOP_B,  32'h103, 32'h0, 0, 32'hFFFFFF80));
        tbl.push_back(mk(0, MEMOP_BU, 32'h103, 32'h0, 0, 32'h00000080));
        tbl.push_back(mk(0, MEMOP_H,  32'h102, 32'h0, 0, 32'hFFFF80FF));
        tbl.push_back(mk(0, MEMOP_HU, 32'h100, 32'h0, 0, 32'h00007F01));
        tbl.push_back(mk(0, MEMOP_B,  32'h100, 32'h0, 0, 32'h00000001));
        tbl.push_back(mk(0, MEMOP_BU, 32'h101, 32'h0, 0, 32'h0000007F));
        tbl.push_back(mk(0, MEMOP_H,  32'h100, 32'h0, 0, 32'h00007F01));
        tbl.push_back(mk(0, MEMOP_HU, 32'h102, 32'h0, 0, 32'h000080FF));
        tbl.push_back(mk(0, MEMOP_W,  32'h102, 32'h0, 1, 32'h0));
        tbl.push_back(mk(1, MEMOP_H,  32'h101, 32'hBEEF, 1, 32'h0));
        tbl.push_back(mk(0, 3'b011,   32'h100, 32'h0, 1, 32'h0));
        tbl.push_back(mk(1, 3'b011,   32'h100, 32'h0, 1, 32'h0));
        tbl.push_back(mk(1, MEMOP_BU, 32'h100, 32'hFF, 1, 32'h0));
        tbl.push_back(mk(0, 3'b110,   32'h100, 32'h0, 1, 32'h0));
        tbl.push_back(mk(0, 3'b111,   32'h100, 32'h0, 1, 32'h0));
        tbl.push_back(mk(0, MEMOP_H,  32'h103, 32'h0, 1, 32'h0));
        tbl.push_back(mk(0, MEMOP_W,  32'h100, 32'h0, 0, 32'h80FF7F01));
        // part B (index 18..): after SB 0xAA at 0x101 the word is 0x80FFAA01
        tbl.push_back(mk(1, MEMOP_H,  32'h102, 32'h1234, 0, 32'h0));
        tbl.push_back(mk(0, MEMOP_W,  32'h100, 32'h0, 0, 32'h1234AA01));
        tbl.push_back(mk(0, MEMOP_HU, 32'h102, 32'h0, 0, 32'h00001234));
        tbl.push_back(mk(0, MEMOP_B,  32'h101, 32'h0, 0, 32'hFFFFFFAA));
        tbl.push_back(mk(1, MEMOP_W,  32'h1000, 32'hCAFEF00D, 0, 32'h0));
        tbl.push_back(mk(0, MEMOP_W,  32'h0, 32'h0, 0, 32'hCAFEF00D));
        tbl.push_back(mk(0, MEMOP_W,  32'h1100, 32'h0, 0, 32'h1234AA01));
        tbl.push_back(mk(1, MEMOP_B,  32'h3, 32'h777, 0, 32'h0));
        tbl.push_back(mk(0, MEMOP_W,  32'h0, 32'h0, 0, 32'h77FEF00D));

        // reset state
        #12;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // back-to-back SW then LW
        req_valid = 1'b1; req_we = 1'b1; req_memop = MEMOP_W; req_addr = 32'h100; req_wdata = 32'h12345678;
        @(posedge clock); #1;
        check("b2b_sw_valid", 32'(resp_valid), 32'd1);
        check("b2b_sw_ready", 32'(req_ready), 32'd1);
        req_we = 1'b0;
        @(posedge clock); #1;
        check("b2b_lw_valid", 32'(resp_valid), 32'd1);
        check("b2b_lw_rdata", resp_rdata, 32'h12345678);
        check("b2b_lw_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;

        run_vecs(0, 18);

        // SB 0xAA to 0x101 followed by a held LW 0x100
        req_valid = 1'b1; req_we = 1'b1; req_memop = MEMOP_B; req_addr = 32'h101; req_wdata = 32'h000000AA;
        @(posedge clock); #1;
        req_we = 1'b0; req_memop = MEMOP_W; req_addr = 32'h100; req_wdata = 32'h0;
`ifdef DMEM_BYTE_ENABLE_EN
        check("sb_ready", 32'(req_ready), 32'd1);
        check("sb_valid", 32'(resp_valid), 32'd1);
`else
        check("sb_ready_low", 32'(req_ready), 32'd0);
        check("sb_no_resp_yet", 32'(resp_valid), 32'd0);
        @(posedge clock); #1;
        check("sb_ready_back", 32'(req_ready), 32'd1);
        check("sb_valid", 32'(resp_valid), 32'd1);
`endif
        check("sb_err", 32'(resp_err), 32'd0);
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("sb_lw_valid", 32'(resp_valid), 32'd1);
        check("sb_lw_rdata", resp_rdata, 32'h80FFAA01);

        run_vecs(18, tbl.size());

        // reset asserted while a sub-word store is pending
        issue(1'b1, MEMOP_W, 32'h200, 32'h11223344, e0, r0, l0);
        check("pre_rst_sw_err", 32'(e0), 32'd0);
        req_valid = 1'b1; req_we = 1'b1; req_memop = MEMOP_B; req_addr = 32'h200; req_wdata = 32'h55;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #2;
        check("midrst_valid", 32'(resp_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        check("midrst_no_resp", 32'(resp_valid), 32'd0);
        issue(1'b0, MEMOP_W, 32'h200, 32'h0, e0, r0, l0);
`ifdef DMEM_BYTE_ENABLE_EN
        check("midrst_word", r0, 32'h11223355);
`else
        check("midrst_word", r0, 32'h11223344);
`endif
        check("midrst_lw_lat", 32'(l0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
